// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for a 5-stage CPU. Detects
//               load-use and ID-stage branch-operand hazards, holds PC and
//               IF/ID, bubbles ID/EX, flushes IF/ID on taken branches, and
//               keeps saturating stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             idIsBranch,
  input  logic             branchTaken,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [4:0]       exRd,
  input  logic             memMemRead,
  input  logic [4:0]       memRd,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             idExFlush,
  output logic             ifIdFlush,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stallCount_q, stallCount_d;
  logic [CNT_W-1:0] flushCount_q, flushCount_d;

  logic             exMatch;
  logic             memMatch;
  logic [1:0]       need;

  // Source-register match of the ID instruction against EX and MEM destinations;
  // $0 is hard-wired zero and therefore never a dependency.
  always_comb begin
    exMatch  = (exRd != 5'd0) &&
               ((exRd == idRs) || (idUsesRt && (exRd == idRt)));
    memMatch = (memRd != 5'd0) &&
               ((memRd == idRs) || (idUsesRt && (memRd == idRt)));
  end

  // Stall length required by the current ID instruction; a branch on a load
  // still in EX needs two cycles because the comparator sits in ID.
  always_comb begin
    need = 2'd0;
    if (exMemRead && idIsBranch && exMatch) begin
      need = 2'd2;
    end else if ((exMemRead && !idIsBranch && exMatch) ||
                 (idIsBranch && exRegWrite && !exMemRead && exMatch) ||
                 (idIsBranch && memMemRead && memMatch)) begin
      need = 2'd1;
    end
  end

  // Next-state and control outputs; reset forces the safe stall+squash pattern.
  always_comb begin
    state_d   = RUN;
    pcWrite   = 1'b0;
    ifIdWrite = 1'b0;
    idExFlush = 1'b1;
    ifIdFlush = 1'b0;
    if (!reset) begin
      ifIdFlush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (need == 2'd0) begin
            pcWrite   = 1'b1;
            ifIdWrite = 1'b1;
            idExFlush = 1'b0;
            ifIdFlush = idIsBranch && branchTaken;
          end else if (need == 2'd2) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Saturating event counters: stall cycles and taken-branch flushes.
  always_comb begin
    stallCount_d = stallCount_q;
    flushCount_d = flushCount_q;
    if (!pcWrite && (stallCount_q != CNT_MAX)) begin
      stallCount_d = stallCount_q + CNT_ONE;
    end
    if (ifIdFlush && (flushCount_q != CNT_MAX)) begin
      flushCount_d = flushCount_q + CNT_ONE;
    end
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      stallCount_q <= '0;
      flushCount_q <= '0;
    end else begin
      state_q      <= state_d;
      stallCount_q <= stallCount_d;
      flushCount_q <= flushCount_d;
    end
  end

  assign stallCount = stallCount_q;
  assign flushCount = flushCount_q;

endmodule
`default_nettype wire
